// File: rtl/subtrator_serial.sv
// Bit-serial WIDTH-bit subtractor (A - B), LSB first, one full-subtractor cell
// and a borrow flop. Operands come from SW, the result and handshake flags go
// to LEDR. KEY[0] is the asynchronous active-low reset; KEY[1] is the start button.
module subtrator_serial #(
  parameter int WIDTH = 5
) (
  input  logic                 CLOCK_50,
  input  logic [2:0]           KEY,
  input  logic [2*WIDTH-1:0]   SW,
  output logic [WIDTH+2:0]     LEDR
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic clk;
  logic rst_n;
  logic key_unused;

  assign clk        = CLOCK_50;
  assign rst_n      = KEY[0];
  assign key_unused = KEY[2];

  state_t state;
  state_t next_state;

  logic             btn_s1;
  logic             btn_s2;
  logic             btn_s3;
  logic             start;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             bor;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] res_diff;
  logic             res_bor;

  logic             load;
  logic             step;
  logic             finish;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             bor_next;

  // Synchronise the start button and keep one extra stage for press-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      btn_s1 <= KEY[1];
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  // A press is a high-to-low transition of the synchronised button (one pulse per press).
  assign start = btn_s3 & ~btn_s2;

  // Full-subtractor cell working on the current LSBs.
  assign a_bit    = a_sh[0];
  assign b_bit    = b_sh[0];
  assign d_bit    = a_bit ^ b_bit ^ bor;
  assign bor_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bor);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and datapath control; start pulses during RUN are ignored.
  // NOTE: every output of this block gets a default first so that no path
  // through the case leaves a signal unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count == LAST) begin
          next_state = DONE;
          finish     = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          next_state = RUN;
          load       = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand shifters, borrow, bit counter and partial difference.
  // NOTE: the whole datapath is cleared by reset because an aborted operation
  // must leave nothing visible; these are plain flops, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      bor   <= 1'b0;
      count <= '0;
    end else if (load) begin
      a_sh  <= SW[WIDTH-1:0];
      b_sh  <= SW[2*WIDTH-1:WIDTH];
      d_sh  <= '0;
      bor   <= 1'b0;
      count <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      d_sh  <= {d_bit, d_sh[WIDTH-1:1]};
      bor   <= bor_next;
      count <= count + 1'b1;
    end
  end

  // Result register: updated only on the RUN->DONE transition, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_diff <= '0;
      res_bor  <= 1'b0;
    end else if (finish) begin
      res_diff <= {d_bit, d_sh[WIDTH-1:1]};
      res_bor  <= bor_next;
    end
  end

  // LEDR is driven purely from registers: no combinational path from SW or KEY[1].
  assign LEDR = {(state == DONE), (state == RUN), res_bor, res_diff};

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial (WIDTH=5): table of directed vectors,
// hand-written multi-cycle corner cases, then all 1024 operand pairs.
module tb_subtrator_serial;

  localparam int W = 5;

  logic           clk;
  logic [2:0]     key;
  logic [2*W-1:0] sw;
  logic [W+2:0]   ledr;

  int n_cmp  = 0;
  int n_fail = 0;

  subtrator_serial #(.WIDTH(W)) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .SW       (sw),
    .LEDR     (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bor;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One-cycle press, then wait (bounded) for the busy window and count it.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int busy_n, output logic [W+2:0] led);
    int wait_n;
    sw     = {b, a};
    key[1] = 1'b0;
    @(negedge clk);
    key[1] = 1'b1;
    wait_n = 0;
    busy_n = 0;
    while (!ledr[W+1] && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    while (ledr[W+1] && busy_n < 20) begin
      busy_n++;
      @(negedge clk);
    end
    led = ledr;
  endtask

  vec_t vecs[7];

  initial begin
    int           busy_n;
    logic [W+2:0] led;
    int           windows;
    int           busy_total;
    logic         prev_busy;
    int           bad;
    int           wait_n;
    logic [W:0]   exp6;

    vecs[0] = '{a: 5'd13, b: 5'd5,  diff: 5'b01000, bor: 1'b0};
    vecs[1] = '{a: 5'd5,  b: 5'd13, diff: 5'b11000, bor: 1'b1};
    vecs[2] = '{a: 5'd31, b: 5'd31, diff: 5'd0,     bor: 1'b0};
    vecs[3] = '{a: 5'd0,  b: 5'd1,  diff: 5'd31,    bor: 1'b1};
    vecs[4] = '{a: 5'd20, b: 5'd7,  diff: 5'd13,    bor: 1'b0};
    vecs[5] = '{a: 5'd0,  b: 5'd31, diff: 5'd1,     bor: 1'b1};
    vecs[6] = '{a: 5'd31, b: 5'd0,  diff: 5'd31,    bor: 1'b0};

    // Reset.
    key = 3'b110;
    sw  = '0;
    idle_cycles(3);
    check("reset_ledr", 32'(ledr), 32'd0);
    key[0] = 1'b1;
    idle_cycles(4);
    check("idle_after_reset", 32'(ledr), 32'd0);

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, busy_n, led);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'(W));
      check($sformatf("vec%0d_done", i), 32'(led[W+2]), 32'd1);
      check($sformatf("vec%0d_diff", i), 32'(led[W-1:0]), 32'(vecs[i].diff));
      check($sformatf("vec%0d_borrow", i), 32'(led[W]), 32'(vecs[i].bor));
      idle_cycles(2);
    end

    // Hold KEY[1] low for 20 cycles: exactly one busy window of WIDTH cycles.
    sw         = {5'd3, 5'd9};
    key[1]     = 1'b0;
    windows    = 0;
    busy_total = 0;
    prev_busy  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ledr[W+1] && !prev_busy) windows++;
      if (ledr[W+1]) busy_total++;
      prev_busy = ledr[W+1];
    end
    check("hold_windows", 32'(windows), 32'd1);
    check("hold_busy_cycles", 32'(busy_total), 32'(W));
    check("hold_done", 32'(ledr[W+2]), 32'd1);
    key[1] = 1'b1;
    idle_cycles(4);
    check("hold_release_ledr", 32'(ledr), {24'd0, 3'b100, 5'd6});

    // Press again and change SW during RUN: no restart, latched operands used.
    sw     = {5'd7, 5'd20};
    key[1] = 1'b0;
    @(negedge clk);
    key[1] = 1'b1;
    wait_n = 0;
    while (!ledr[W+1] && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    busy_n = 0;
    while (ledr[W+1] && busy_n < 20) begin
      busy_n++;
      if (busy_n == 2) begin
        sw     = {5'd31, 5'd0};
        key[1] = 1'b0;
      end else begin
        key[1] = 1'b1;
      end
      @(negedge clk);
    end
    key[1] = 1'b1;
    check("midrun_busy_cycles", 32'(busy_n), 32'(W));
    check("midrun_result", 32'(ledr), {24'd0, 3'b100, 5'd13});
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ledr[W+1] || !ledr[W+2]) bad++;
    end
    check("midrun_no_restart", 32'(bad), 32'd0);

    // Reset on the 3rd RUN cycle: LEDR clears immediately, no result afterwards.
    sw     = {5'd1, 5'd30};
    key[1] = 1'b0;
    @(negedge clk);
    key[1] = 1'b1;
    wait_n = 0;
    while (!ledr[W+1] && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    check("abort_busy_seen", 32'(ledr[W+1]), 32'd1);
    idle_cycles(2);
    key[0] = 1'b0;
    #1;
    check("abort_ledr_async", 32'(ledr), 32'd0);
    @(negedge clk);
    key[0] = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ledr != '0) bad++;
    end
    check("abort_stays_idle", 32'(bad), 32'd0);

    // Exhaustive sweep, back-to-back DONE->RUN restarts.
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        run_op(W'(a), W'(b), busy_n, led);
        exp6 = {1'b0, W'(a)} - {1'b0, W'(b)};
        check($sformatf("ex_%0d_%0d_result", a, b), 32'(led[W:0]), 32'(exp6));
        check($sformatf("ex_%0d_%0d_latency", a, b), 32'(busy_n), 32'(W));
        check($sformatf("ex_%0d_%0d_flags", a, b), 32'(led[W+2:W+1]), 32'd2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
